// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - pipeline fetch stage reading a 1-cycle-latency instruction ROM
module instruction_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [DATA_W-1:0] NOP      = 32'h0,
  parameter logic [7:0]        HALT_OP  = 8'hFF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              JUMP,
  input  logic [ADDR_W-1:0] JUMP_ADDR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic              VALID,
  output logic              HALTED
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // pc: next address to issue; addr_q: address whose word the ROM returns this cycle
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_v;
  logic [0:0]        state;
  logic              halt_word;

  // While stalled the in-flight address is replayed so MEM_DATA keeps matching addr_q
  assign MEM_ADDR  = STALL ? addr_q : pc;
  assign halt_word = addr_v && (MEM_DATA[DATA_W-1 -: 8] == HALT_OP);
  assign HALTED    = (state == ST_HALTED);

  // Fetch pipeline update: reset > jump > stall > run/halted behaviour
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      addr_v <= 1'b0;
      INSTR  <= NOP;
      PC_OUT <= '0;
      VALID  <= 1'b0;
      state  <= ST_RUN;
    end else if (JUMP) begin
      // Redirect and drop both the word in flight and the one being delivered
      pc     <= JUMP_ADDR;
      addr_v <= 1'b0;
      INSTR  <= NOP;
      VALID  <= 1'b0;
      state  <= ST_RUN;
    end else if (STALL) begin
      // Whole stage frozen
      pc     <= pc;
    end else if (state == ST_RUN) begin
      INSTR  <= MEM_DATA;
      PC_OUT <= addr_q;
      VALID  <= addr_v;
      addr_q <= pc;
      pc     <= pc + 1'b1;
      if (halt_word) begin
        // Halt word is still delivered; nothing fetched after it is valid
        addr_v <= 1'b0;
        state  <= ST_HALTED;
      end else begin
        addr_v <= 1'b1;
      end
    end else begin
      // Halted: the halt word is retired on the first unstalled edge
      INSTR  <= NOP;
      VALID  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL;
  logic        JUMP;
  logic [7:0]  JUMP_ADDR;
  logic [7:0]  MEM_ADDR;
  logic [31:0] MEM_DATA;
  logic [31:0] INSTR;
  logic [7:0]  PC_OUT;
  logic        VALID;
  logic        HALTED;

  logic [31:0] rom [0:255];
  int          n_total = 0;
  int          n_pass  = 0;

  instruction_fetch dut (
    .CLK       (CLK),
    .RST       (RST),
    .STALL     (STALL),
    .JUMP      (JUMP),
    .JUMP_ADDR (JUMP_ADDR),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DATA  (MEM_DATA),
    .INSTR     (INSTR),
    .PC_OUT    (PC_OUT),
    .VALID     (VALID),
    .HALTED    (HALTED)
  );

  always #5 CLK = ~CLK;

  // Registered ROM, one cycle read latency
  always @(posedge CLK) MEM_DATA <= rom[MEM_ADDR];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] ins, input logic [7:0] pc);
    check({tag, ".valid"}, {31'b0, VALID}, {31'b0, v});
    check({tag, ".instr"}, INSTR, ins);
    check({tag, ".pc_out"}, {24'b0, PC_OUT}, {24'b0, pc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) rom[i] = i;
    RST = 1'b1; STALL = 1'b0; JUMP = 1'b0; JUMP_ADDR = 8'h00;

    // 1: reset state and first fetches
    step(); step();
    check_out("reset", 1'b0, 32'h0, 8'h00);
    check("reset.halted", {31'b0, HALTED}, 32'h0);
    check("reset.mem_addr", {24'b0, MEM_ADDR}, 32'h0);
    RST = 1'b0;
    step();
    check("cyc1.valid", {31'b0, VALID}, 32'h0);
    step();
    check_out("cyc2", 1'b1, 32'h0, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_out($sformatf("run%0d", k), 1'b1, k, k[7:0]);
    end

    // 2: stall for 3 cycles while INSTR=5 (addr_q=6, pc=7)
    STALL = 1'b1;
    #1;
    check("stall.mem_addr", {24'b0, MEM_ADDR}, 32'h6);
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("stall%0d", k), 1'b1, 32'h5, 8'h05);
      check($sformatf("stall%0d.mem_addr", k), {24'b0, MEM_ADDR}, 32'h6);
    end
    STALL = 1'b0;
    step();
    check_out("post_stall6", 1'b1, 32'h6, 8'h06);
    step();
    check_out("post_stall7", 1'b1, 32'h7, 8'h07);

    // 3: jump to 0x40 with stall also high
    JUMP = 1'b1; JUMP_ADDR = 8'h40; STALL = 1'b1;
    step();
    JUMP = 1'b0; STALL = 1'b0;
    check("jmp.n1.valid", {31'b0, VALID}, 32'h0);
    check("jmp.n1.instr", INSTR, 32'h0);
    step();
    check("jmp.n2.valid", {31'b0, VALID}, 32'h0);
    step();
    check_out("jmp.n3", 1'b1, 32'h40, 8'h40);
    step();
    check_out("jmp.n4", 1'b1, 32'h41, 8'h41);

    // 4: halt word at address 3
    rom[3] = 32'hFF00_0000;
    JUMP = 1'b1; JUMP_ADDR = 8'h00;
    step();
    JUMP = 1'b0;
    step(); step();
    check_out("hlt.i0", 1'b1, 32'h0, 8'h00);
    step(); step();
    check_out("hlt.i2", 1'b1, 32'h2, 8'h02);
    check("hlt.i2.halted", {31'b0, HALTED}, 32'h0);
    step();
    check_out("hlt.word", 1'b1, 32'hFF00_0000, 8'h03);
    check("hlt.word.halted", {31'b0, HALTED}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("hlt.idle%0d.valid", k), {31'b0, VALID}, 32'h0);
      check($sformatf("hlt.idle%0d.instr", k), INSTR, 32'h0);
      check($sformatf("hlt.idle%0d.halted", k), {31'b0, HALTED}, 32'h1);
    end
    rom[3] = 32'h3;
    JUMP = 1'b1; JUMP_ADDR = 8'h00;
    step();
    JUMP = 1'b0;
    check("unhalt.halted", {31'b0, HALTED}, 32'h0);
    step(); step();
    check_out("unhalt.i0", 1'b1, 32'h0, 8'h00);

    // 5: reset mid-stream while stalled with pc=0x20 (INSTR=0x1E)
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      step();
      if (VALID && PC_OUT == 8'h1E) found = 1'b1;
    end
    check("rst.reach_1e", {31'b0, found}, 32'h1);
    STALL = 1'b1; RST = 1'b1;
    step();
    RST = 1'b0; STALL = 1'b0;
    check_out("rst.mid", 1'b0, 32'h0, 8'h00);
    check("rst.mid.mem_addr", {24'b0, MEM_ADDR}, 32'h0);
    step();
    check("rst.c1.valid", {31'b0, VALID}, 32'h0);
    step();
    check_out("rst.c2", 1'b1, 32'h0, 8'h00);
    step();
    check_out("rst.c3", 1'b1, 32'h1, 8'h01);

    // 6: wrap-around from 0xFE
    JUMP = 1'b1; JUMP_ADDR = 8'hFE;
    step();
    JUMP = 1'b0;
    step(); step();
    check_out("wrap.fe", 1'b1, 32'hFE, 8'hFE);
    step();
    check_out("wrap.ff", 1'b1, 32'hFF, 8'hFF);
    step();
    check_out("wrap.00", 1'b1, 32'h0, 8'h00);
    step();
    check_out("wrap.01", 1'b1, 32'h1, 8'h01);

    // 7: jump coinciding with halt capture wins
    rom[3] = 32'hFF00_0000;
    JUMP = 1'b1; JUMP_ADDR = 8'h00;
    step();
    JUMP = 1'b0;
    step(); step(); step(); step();
    check_out("jh.i2", 1'b1, 32'h2, 8'h02);
    JUMP = 1'b1; JUMP_ADDR = 8'h10;
    step();
    JUMP = 1'b0;
    check("jh.n1.halted", {31'b0, HALTED}, 32'h0);
    check("jh.n1.valid", {31'b0, VALID}, 32'h0);
    step(); step();
    check_out("jh.n3", 1'b1, 32'h10, 8'h10);
    check("jh.n3.halted", {31'b0, HALTED}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
